// File: rtl/pc_sequencer_pkg.sv
// Shared CPU defines for the instruction-fetch path: default widths and
// the fetch sequencer state encodings.
package pc_sequencer_pkg;

    localparam int PCSEQ_ADDR_WIDTH  = 16;
    localparam int PCSEQ_INSTR_WIDTH = 16;

    typedef enum logic [2:0] {
        PCSEQ_IDLE   = 3'd0,
        PCSEQ_REQ    = 3'd1,
        PCSEQ_WAIT   = 3'd2,
        PCSEQ_DROP   = 3'd3,
        PCSEQ_HALTED = 3'd4
    } pcseq_state_e;

endpackage

// File: rtl/pc_sequencer.sv
// Instruction-fetch sequencer: owns the PC, issues one imem read at a time
// and hands instructions to decode through a one-entry valid/ready buffer.
//
// state  | meaning
// IDLE   | first cycle after reset, no request yet
// REQ    | presenting pc to imem when the buffer is free and not halted
// WAIT   | one good request outstanding, response loads the buffer
// DROP   | one stale request outstanding, response is discarded
// HALTED | no new requests until halt drops; buffer still drains
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = PCSEQ_ADDR_WIDTH,
    parameter int                    INSTR_WIDTH = PCSEQ_INSTR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [ADDR_WIDTH-1:0]  imem_req_addr,
    input  logic                   imem_rsp_valid,
    input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
    output logic                   instr_valid,
    output logic [INSTR_WIDTH-1:0] instr_data,
    output logic [ADDR_WIDTH-1:0]  instr_pc,
    input  logic                   instr_ready,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_target,
    input  logic                   halt
);

    pcseq_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [ADDR_WIDTH-1:0]  req_pc_q, req_pc_d;
    logic                   instr_valid_q, instr_valid_d;
    logic [INSTR_WIDTH-1:0] instr_data_q, instr_data_d;
    logic [ADDR_WIDTH-1:0]  instr_pc_q, instr_pc_d;

    logic         buf_free;
    logic         req_fire;
    pcseq_state_e resume_state;

    assign buf_free       = !instr_valid_q || instr_ready;
    assign imem_req_valid = (state_q == PCSEQ_REQ) && buf_free && !halt;
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign resume_state   = halt ? PCSEQ_HALTED : PCSEQ_REQ;

    assign instr_valid = instr_valid_q;
    assign instr_data  = instr_data_q;
    assign instr_pc    = instr_pc_q;

    // State, PC and output buffer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= PCSEQ_IDLE;
            pc_q          <= RESET_PC;
            req_pc_q      <= RESET_PC;
            instr_valid_q <= 1'b0;
            instr_data_q  <= '0;
            instr_pc_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            req_pc_q      <= req_pc_d;
            instr_valid_q <= instr_valid_d;
            instr_data_q  <= instr_data_d;
            instr_pc_q    <= instr_pc_d;
        end
    end

    // Next-state, PC update and buffer load/drain; redirect overrides all.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        req_pc_d      = req_pc_q;
        instr_valid_d = instr_valid_q;
        instr_data_d  = instr_data_q;
        instr_pc_d    = instr_pc_q;

        if (instr_valid_q && instr_ready) begin
            instr_valid_d = 1'b0;
        end

        if (redirect_valid) begin
            pc_d          = redirect_target;
            instr_valid_d = 1'b0;
            case (state_q)
                PCSEQ_IDLE:   state_d = resume_state;
                PCSEQ_REQ:    state_d = req_fire ? PCSEQ_DROP : PCSEQ_REQ;
                PCSEQ_WAIT:   state_d = imem_rsp_valid ? PCSEQ_REQ : PCSEQ_DROP;
                // A response arriving now is the last stale one; nothing
                // remains outstanding, so waiting in DROP would never end.
                PCSEQ_DROP:   state_d = imem_rsp_valid ? resume_state : PCSEQ_DROP;
                PCSEQ_HALTED: state_d = halt ? PCSEQ_HALTED : PCSEQ_REQ;
                default:      state_d = PCSEQ_IDLE;
            endcase
        end else begin
            case (state_q)
                PCSEQ_IDLE: begin
                    state_d = resume_state;
                end
                PCSEQ_REQ: begin
                    if (req_fire) begin
                        req_pc_d = pc_q;
                        pc_d     = pc_q + ADDR_WIDTH'(1);
                        state_d  = PCSEQ_WAIT;
                    end
                end
                PCSEQ_WAIT: begin
                    if (imem_rsp_valid) begin
                        instr_valid_d = 1'b1;
                        instr_data_d  = imem_rsp_data;
                        instr_pc_d    = req_pc_q;
                        state_d       = resume_state;
                    end
                end
                PCSEQ_DROP: begin
                    if (imem_rsp_valid) begin
                        state_d = resume_state;
                    end
                end
                PCSEQ_HALTED: begin
                    if (!halt) begin
                        state_d = PCSEQ_REQ;
                    end
                end
                default: begin
                    state_d = PCSEQ_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: behavioural imem with programmable latency, a
// request-address model, a queue of expected deliveries, a table of
// buffer/halt vectors, and directed redirect/halt/reset/wrap sequences.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [15:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [15:0] imem_rsp_data;
    logic        instr_valid;
    logic [15:0] instr_data;
    logic [15:0] instr_pc;
    logic        instr_ready;
    logic        redirect_valid;
    logic [15:0] redirect_target;
    logic        halt;

    logic        rst_w = 1'b0;
    logic        w_req_valid;
    logic        w_req_ready;
    logic [15:0] w_req_addr;
    logic        w_rsp_valid;
    logic [15:0] w_rsp_data;
    logic        w_instr_valid;
    logic [15:0] w_instr_data;
    logic [15:0] w_instr_pc;
    logic        w_instr_ready;
    logic        w_redirect_valid;
    logic [15:0] w_redirect_target;
    logic        w_halt;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .instr_valid(instr_valid), .instr_data(instr_data), .instr_pc(instr_pc),
        .instr_ready(instr_ready),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .halt(halt)
    );

    pc_sequencer #(.RESET_PC(16'hFFFF)) dut_w (
        .clk(clk), .rst(rst_w),
        .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready),
        .imem_req_addr(w_req_addr),
        .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
        .instr_valid(w_instr_valid), .instr_data(w_instr_data), .instr_pc(w_instr_pc),
        .instr_ready(w_instr_ready),
        .redirect_valid(w_redirect_valid), .redirect_target(w_redirect_target),
        .halt(w_halt)
    );

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] data;
    } exp_t;

    typedef struct {
        logic        rdy;
        logic        hlt;
        logic        exp_req;
        logic        exp_vld;
        logic [15:0] exp_addr;
    } row_t;

    exp_t        exp_q[$];
    logic [15:0] exp_next;
    int          ncmp = 0;
    int          nerr = 0;

    bit          mem_busy = 1'b0;
    int          mem_cnt  = 0;
    int          mem_lat  = 1;
    logic [15:0] mem_addr = '0;

    logic        last_fire;
    logic [15:0] last_fire_addr;
    logic        last_cons;
    logic [15:0] last_cons_pc;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'h1231;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        ncmp++;
        nerr++;
        $display("FAIL %s: timed out at %0t", nm, $time);
    endtask

    task automatic mem_drive();
        imem_rsp_valid = mem_busy && (mem_cnt == 0);
        imem_rsp_data  = imem_rsp_valid ? mem_word(mem_addr) : 16'hDEAD;
    endtask

    // One clock: starts and ends at a falling edge.
    task automatic tick();
        logic        fire, cons;
        logic [15:0] a, cpc, cdat;
        exp_t        e;
        #1;
        fire = imem_req_valid && imem_req_ready;
        a    = imem_req_addr;
        cons = instr_valid && instr_ready;
        cpc  = instr_pc;
        cdat = instr_data;
        if (halt) chk("halt_no_req", 16'(imem_req_valid), 16'd0);
        if (instr_valid && !instr_ready) chk("bp_no_req", 16'(imem_req_valid), 16'd0);
        if (cons) begin
            if (exp_q.size() == 0) begin
                ncmp++;
                nerr++;
                $display("FAIL unexpected_instr: got pc %h data %h expected none", cpc, cdat);
            end else begin
                e = exp_q.pop_front();
                chk("instr_pc", cpc, e.pc);
                chk("instr_data", cdat, e.data);
            end
        end
        if (fire) begin
            chk("one_outstanding", 16'(mem_busy), 16'd0);
            chk("req_addr", a, exp_next);
            exp_next = exp_next + 16'd1;
            exp_q.push_back('{pc: a, data: mem_word(a)});
        end
        if (redirect_valid) begin
            exp_q.delete();
            exp_next = redirect_target;
        end
        last_fire      = fire;
        last_fire_addr = a;
        last_cons      = cons;
        last_cons_pc   = cpc;
        @(posedge clk);
        if (imem_rsp_valid) mem_busy = 1'b0;
        else if (mem_busy) mem_cnt--;
        if (fire) begin
            mem_busy = 1'b1;
            mem_cnt  = mem_lat - 1;
            mem_addr = a;
        end
        @(negedge clk);
        mem_drive();
    endtask

    task automatic wait_cons(input logic [15:0] pc, input int budget, input string nm);
        bit got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            tick();
            if (last_cons && last_cons_pc == pc) got = 1'b1;
        end
        if (!got) timeout(nm);
    endtask

    task automatic wait_fire(input int budget, input string nm);
        bit got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            tick();
            if (last_fire) got = 1'b1;
        end
        if (!got) timeout(nm);
    endtask

    task automatic redirect(input logic [15:0] tgt);
        redirect_valid  = 1'b1;
        redirect_target = tgt;
        tick();
        redirect_valid  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        row_t        rows[6];
        logic [15:0] a;
        bit          done;

        rows[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000};
        rows[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0000};
        rows[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0000};
        rows[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
        rows[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0006};
        rows[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0006};

        imem_req_ready  = 1'b1;
        instr_ready     = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        halt            = 1'b0;
        w_req_ready       = 1'b1;
        w_rsp_valid       = 1'b0;
        w_rsp_data        = '0;
        w_instr_ready     = 1'b1;
        w_redirect_valid  = 1'b0;
        w_redirect_target = '0;
        w_halt            = 1'b0;
        mem_drive();

        // Reset values
        #1;
        rst   = 1'b1;
        rst_w = 1'b1;
        #2;
        chk("rst_req_valid", 16'(imem_req_valid), 16'd0);
        chk("rst_instr_valid", 16'(instr_valid), 16'd0);
        chk("rst_req_addr", imem_req_addr, 16'h0000);
        chk("rst_instr_data", instr_data, 16'h0000);
        chk("rst_instr_pc", instr_pc, 16'h0000);
        @(negedge clk);
        tick();
        tick();
        chk("rst_hold_req_valid", 16'(imem_req_valid), 16'd0);
        chk("rst_hold_instr_valid", 16'(instr_valid), 16'd0);

        // Sequential fetch from RESET_PC with 1-cycle memory
        exp_next    = 16'h0000;
        rst         = 1'b0;
        instr_ready = 1'b1;
        wait_cons(16'h0003, 40, "seq_fetch");

        // Backpressure: buffer holds pc 5 while decode stalls
        instr_ready    = 1'b0;
        imem_req_ready = 1'b0;
        repeat (4) tick();
        redirect(16'h0005);
        chk("redir_clears_buf", 16'(instr_valid), 16'd0);
        imem_req_ready = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin
            tick();
            if (instr_valid) done = 1'b1;
        end
        if (!done) timeout("bp_load");
        chk("bp_data", instr_data, 16'h1234);
        chk("bp_pc", instr_pc, 16'h0005);
        repeat (5) tick();
        chk("bp_hold_data", instr_data, 16'h1234);
        chk("bp_hold_pc", instr_pc, 16'h0005);

        // Request gating vectors in REQ with the buffer full, memory not ready
        imem_req_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            instr_ready = rows[i].rdy;
            halt        = rows[i].hlt;
            #1;
            chk("tbl_req_valid", 16'(imem_req_valid), 16'(rows[i].exp_req));
            chk("tbl_instr_valid", 16'(instr_valid), 16'(rows[i].exp_vld));
            if (rows[i].exp_req) chk("tbl_req_addr", imem_req_addr, rows[i].exp_addr);
            tick();
        end

        // Redirect while WAIT: response for 7 dropped, fetch resumes at 0x40
        halt        = 1'b0;
        instr_ready = 1'b1;
        redirect(16'h0007);
        mem_lat        = 3;
        imem_req_ready = 1'b1;
        wait_fire(5, "wait_fire_7");
        chk("fired_7", last_fire_addr, 16'h0007);
        redirect(16'h0040);
        chk("wait_redir_no_valid", 16'(instr_valid), 16'd0);
        wait_cons(16'h0040, 30, "redir_wait_0x40");

        // Redirect coincident with request handshake
        mem_lat = 1;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            #1;
            if (imem_req_valid && imem_req_ready) begin
                redirect(16'h0080);
                done = 1'b1;
            end else begin
                tick();
            end
        end
        if (!done) timeout("hs_redirect");
        chk("hs_redir_no_valid", 16'(instr_valid), 16'd0);
        wait_cons(16'h0080, 30, "hs_redir_0x80");

        // Redirect coincident with response
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (imem_rsp_valid) begin
                redirect(16'h0080);
                done = 1'b1;
            end else begin
                tick();
            end
        end
        if (!done) timeout("rsp_redirect");
        chk("rsp_redir_no_valid", 16'(instr_valid), 16'd0);
        wait_cons(16'h0080, 30, "rsp_redir_0x80");

        // Halt during WAIT: response delivered, no requests, resume at next pc
        mem_lat = 2;
        wait_fire(10, "halt_fire");
        a    = last_fire_addr;
        halt = 1'b1;
        wait_cons(a, 10, "halt_deliver");
        repeat (4) tick();
        halt = 1'b0;
        wait_fire(10, "halt_resume");
        chk("resume_pc", last_fire_addr, 16'(a + 16'd1));

        // Reset in WAIT: back to IDLE with pc = RESET_PC
        mem_lat = 3;
        wait_fire(10, "rst_fire");
        rst = 1'b1;
        #1;
        chk("midrst_req_valid", 16'(imem_req_valid), 16'd0);
        chk("midrst_instr_valid", 16'(instr_valid), 16'd0);
        chk("midrst_req_addr", imem_req_addr, 16'h0000);
        chk("midrst_instr_pc", instr_pc, 16'h0000);
        mem_busy = 1'b0;
        exp_q.delete();
        exp_next = 16'h0000;
        mem_drive();
        tick();
        rst = 1'b0;
        wait_cons(16'h0000, 10, "midrst_refetch");

        // Wrap-around with RESET_PC = 0xFFFF
        rst_w = 1'b0;
        @(negedge clk);
        chk("wrap_req_valid", 16'(w_req_valid), 16'd1);
        chk("wrap_first_addr", w_req_addr, 16'hFFFF);
        @(negedge clk);
        w_rsp_valid = 1'b1;
        w_rsp_data  = 16'hABCD;
        @(negedge clk);
        w_rsp_valid = 1'b0;
        chk("wrap_instr_valid", 16'(w_instr_valid), 16'd1);
        chk("wrap_instr_pc", w_instr_pc, 16'hFFFF);
        chk("wrap_instr_data", w_instr_data, 16'hABCD);
        chk("wrap_next_addr", w_req_addr, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
